// File: rtl/tivi_bus_master_if.sv
// Request/response port and TIVI pin bundle for the TIVI register-bus initiator.
// The master modport is the initiator's view; slave is the host/pad side.
interface tivi_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_rs;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_we;
  logic [7:0] rsp_rdata;
  logic       csb;
  logic       rdb;
  logic       wrb;
  logic [3:0] rs;
  logic [7:0] dout;
  logic       dout_en;
  logic [7:0] din;

  modport master (
    input  req_valid, req_we, req_rs, req_wdata, din,
    output req_ready, rsp_valid, rsp_we, rsp_rdata,
           csb, rdb, wrb, rs, dout, dout_en
  );

  modport slave (
    output req_valid, req_we, req_rs, req_wdata, din,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata,
           csb, rdb, wrb, rs, dout, dout_en
  );
endinterface

// File: rtl/tivi_bus_master.sv
// Host-side TIVI register-bus initiator: one access at a time, registered strobes with
// programmable setup / strobe / hold / recovery cycle counts.
module tivi_bus_master #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 6,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 4
) (
  input logic               clk,
  input logic               reset,
  tivi_bus_master_if.master bus
);
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);
  // The IDLE cycle that accepts the next request is the last csb-high cycle, so
  // RECOVER itself lasts one cycle less and is skipped entirely when RECOVER_CYC is 1.
  localparam logic [3:0] RECOVER_LOAD = 4'((RECOVER_CYC > 1) ? RECOVER_CYC - 2 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       we_reg, we_next;
  logic       csb_reg, csb_next;
  logic       rdb_reg, rdb_next;
  logic       wrb_reg, wrb_next;
  logic [3:0] rs_reg, rs_next;
  logic [7:0] dout_reg, dout_next;
  logic       dout_en_reg, dout_en_next;
  logic       rsp_valid_reg, rsp_valid_next;
  logic       rsp_we_reg, rsp_we_next;
  logic [7:0] rsp_rdata_reg, rsp_rdata_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      csb_reg       <= 1'b1;
      rdb_reg       <= 1'b1;
      wrb_reg       <= 1'b1;
      rs_reg        <= 4'd0;
      dout_reg      <= 8'd0;
      dout_en_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_we_reg    <= 1'b0;
      rsp_rdata_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      csb_reg       <= csb_next;
      rdb_reg       <= rdb_next;
      wrb_reg       <= wrb_next;
      rs_reg        <= rs_next;
      dout_reg      <= dout_next;
      dout_en_reg   <= dout_en_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_we_reg    <= rsp_we_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = (cnt_reg != 4'd0) ? cnt_reg - 4'd1 : cnt_reg;
    we_next        = we_reg;
    csb_next       = csb_reg;
    rdb_next       = rdb_reg;
    wrb_next       = wrb_reg;
    rs_next        = rs_reg;
    dout_next      = dout_reg;
    dout_en_next   = dout_en_reg;
    rsp_valid_next = 1'b0;
    rsp_we_next    = rsp_we_reg;
    rsp_rdata_next = rsp_rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_next  = bus.req_we;
          rs_next  = bus.req_rs;
          csb_next = 1'b0;
          if (bus.req_we) begin
            dout_next    = bus.req_wdata;
            dout_en_next = 1'b1;
          end
          cnt_next   = SETUP_LOAD;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == 4'd0) begin
          rdb_next   = we_reg;
          wrb_next   = !we_reg;
          cnt_next   = STROBE_LOAD;
          state_next = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (cnt_reg == 4'd0) begin
          if (!we_reg) rsp_rdata_next = bus.din;
          rdb_next   = 1'b1;
          wrb_next   = 1'b1;
          cnt_next   = HOLD_LOAD;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == 4'd0) begin
          rsp_valid_next = 1'b1;
          rsp_we_next    = we_reg;
          csb_next       = 1'b1;
          dout_en_next   = 1'b0;
          cnt_next       = RECOVER_LOAD;
          state_next     = (RECOVER_CYC > 1) ? ST_RECOVER : ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (cnt_reg == 4'd0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_we    = rsp_we_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.csb       = csb_reg;
  assign bus.rdb       = rdb_reg;
  assign bus.wrb       = wrb_reg;
  assign bus.rs        = rs_reg;
  assign bus.dout      = dout_reg;
  assign bus.dout_en   = dout_en_reg;
endmodule

// File: tb/tb_tivi_bus_master.sv
// Bench for tivi_bus_master: a default-timing instance and an all-ones-timing instance,
// checked every cycle against an access-timeline model plus directed literal checks.
module tb_tivi_bus_master;
  localparam int MS [0:1] = '{2, 1};
  localparam int MT [0:1] = '{6, 1};
  localparam int MH [0:1] = '{1, 1};
  localparam int MR [0:1] = '{4, 1};

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   checking = 0;

  bit         v_valid [0:1];
  bit         v_we    [0:1];
  logic [3:0] v_rs    [0:1];
  logic [7:0] v_wd    [0:1];
  logic [7:0] rd_val  [0:1];

  tivi_bus_master_if bus0 ();
  tivi_bus_master_if bus1 ();

  tivi_bus_master u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  tivi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus0.req_valid = v_valid[0];
  assign bus0.req_we    = v_we[0];
  assign bus0.req_rs    = v_rs[0];
  assign bus0.req_wdata = v_wd[0];
  assign bus1.req_valid = v_valid[1];
  assign bus1.req_we    = v_we[1];
  assign bus1.req_rs    = v_rs[1];
  assign bus1.req_wdata = v_wd[1];
  // TIVI pad: drives the register value only while its read strobe is low
  assign bus0.din = bus0.rdb ? 8'h00 : rd_val[0];
  assign bus1.din = bus1.rdb ? 8'h00 : rd_val[1];

  // Output vector: [26] ready [25] rsp_valid [24] rsp_we [23:16] rsp_rdata [15] csb
  // [14] rdb [13] wrb [12:9] rs [8:1] dout [0] dout_en
  logic [26:0] ov [0:1];
  assign ov[0] = {bus0.req_ready, bus0.rsp_valid, bus0.rsp_we, bus0.rsp_rdata, bus0.csb,
                  bus0.rdb, bus0.wrb, bus0.rs, bus0.dout, bus0.dout_en};
  assign ov[1] = {bus1.req_ready, bus1.rsp_valid, bus1.rsp_we, bus1.rsp_rdata, bus1.csb,
                  bus1.rdb, bus1.wrb, bus1.rs, bus1.dout, bus1.dout_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each access is a timeline indexed by edges since its acceptance edge.
  bit         m_active    [0:1];
  int         m_d         [0:1];
  bit         m_we        [0:1];
  logic [3:0] last_rs     [0:1];
  logic [7:0] last_dout   [0:1];
  bit         last_rspwe  [0:1];
  logic [7:0] last_rdata  [0:1];

  function automatic bit mready(input int i);
    return !m_active[i] || (m_d[i] >= MS[i] + MT[i] + MH[i] + MR[i] - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_active[i]   <= 1'b0;
        m_d[i]        <= 0;
        m_we[i]       <= 1'b0;
        last_rs[i]    <= 4'd0;
        last_dout[i]  <= 8'd0;
        last_rspwe[i] <= 1'b0;
        last_rdata[i] <= 8'd0;
      end else if (mready(i) && v_valid[i]) begin
        m_active[i] <= 1'b1;
        m_d[i]      <= 0;
        m_we[i]     <= v_we[i];
        last_rs[i]  <= v_rs[i];
        if (v_we[i]) last_dout[i] <= v_wd[i];
      end else if (m_active[i]) begin
        if (m_d[i] < 1000) m_d[i] <= m_d[i] + 1;
        if (m_d[i] + 1 == MS[i] + MT[i] + MH[i]) last_rspwe[i] <= m_we[i];
        if (m_d[i] + 1 == MS[i] + MT[i] && !m_we[i]) last_rdata[i] <= rd_val[i];
      end
    end
  end

  function automatic logic [26:0] exp_vec(input int i);
    bit busy;
    bit strobe;
    busy   = m_active[i] && (m_d[i] < MS[i] + MT[i] + MH[i]);
    strobe = m_active[i] && (m_d[i] >= MS[i]) && (m_d[i] < MS[i] + MT[i]);
    return {mready(i), m_active[i] && (m_d[i] == MS[i] + MT[i] + MH[i]), last_rspwe[i],
            last_rdata[i], !busy, !(strobe && !m_we[i]), !(strobe && m_we[i]),
            last_rs[i], last_dout[i], busy && m_we[i]};
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (ov[i] !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL model_dut%0d t=%0t got=%h expected=%h", i, $time, ov[i], exp_vec(i));
        end
        n_tests++;
        if ((^ov[i]) === 1'bx) begin
          n_fail++;
          $display("FAIL no_x_dut%0d t=%0t got=%h", i, $time, ov[i]);
        end
        n_tests++;
        if (ov[i][14] == 1'b0 && ov[i][13] == 1'b0) begin
          n_fail++;
          $display("FAIL both_strobes_dut%0d t=%0t rdb=0 wrb=0 required not both low", i, $time);
        end
        n_tests++;
        if ((ov[i][14] == 1'b0 || ov[i][13] == 1'b0) && ov[i][15] == 1'b1) begin
          n_fail++;
          $display("FAIL strobe_without_cs_dut%0d t=%0t csb=1 with strobe low", i, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic do_req(input int i, input bit we, input logic [3:0] rs, input logic [7:0] wd);
    int w;
    w = 0;
    @(posedge clk); #2;
    v_valid[i] = 1'b1; v_we[i] = we; v_rs[i] = rs; v_wd[i] = wd;
    @(negedge clk);
    while (!ov[i][26] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_accept_timeout", (w >= 50) ? 1 : 0, 0);
    @(posedge clk); #2;
    v_valid[i] = 1'b0;
  endtask

  logic [26:0] tr [0:15];
  task automatic capture(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tr[k] = ov[i];
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int csb_lo, wrb_lo, rdb_lo, en_hi, wrb_first, rsp_k, p0, p1, rsp_p, rsp_hits, rdy_after;
    logic [7:0] rsp_d;
    for (int i = 0; i < 2; i++) begin
      v_valid[i] = 0; v_we[i] = 0; v_rs[i] = 4'd0; v_wd[i] = 8'd0; rd_val[i] = 8'd0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_vec_dut0", int'(ov[0]), 32'h400E000);
    chk("reset_vec_dut1", int'(ov[1]), 32'h400E000);
    reset = 1'b0;
    checking = 1;

    // Write rs=1 data=0x34, default timing
    do_req(0, 1'b1, 4'd1, 8'h34);
    capture(0, 14);
    csb_lo = 0; wrb_lo = 0; en_hi = 0; wrb_first = -1; rsp_k = -1;
    for (int k = 0; k < 14; k++) begin
      csb_lo += (tr[k][15] == 1'b0) ? 1 : 0;
      wrb_lo += (tr[k][13] == 1'b0) ? 1 : 0;
      en_hi  += tr[k][0] ? 1 : 0;
      if (tr[k][13] == 1'b0 && wrb_first < 0) wrb_first = k;
      if (tr[k][25] && rsp_k < 0) rsp_k = k;
    end
    chk("wr_csb_low_cycles", csb_lo, 9);
    chk("wr_wrb_first_edge", wrb_first, 2);
    chk("wr_wrb_low_cycles", wrb_lo, 6);
    chk("wr_dout_en_cycles", en_hi, 9);
    chk("wr_dout", int'(tr[0][8:1]), 8'h34);
    chk("wr_rsp_edge", rsp_k, 9);
    chk("wr_rsp_we", (rsp_k >= 0) ? int'(tr[rsp_k][24]) : -1, 1);

    // Read rs=3, pad returns 0xC3 only while rdb is low
    rd_val[0] = 8'hC3;
    do_req(0, 1'b0, 4'd3, 8'h00);
    capture(0, 14);
    rdb_lo = 0; en_hi = 0; rsp_k = -1;
    for (int k = 0; k < 14; k++) begin
      rdb_lo += (tr[k][14] == 1'b0) ? 1 : 0;
      en_hi  += tr[k][0] ? 1 : 0;
      if (tr[k][25] && rsp_k < 0) rsp_k = k;
    end
    chk("rd_rdb_low_cycles", rdb_lo, 6);
    chk("rd_dout_en_cycles", en_hi, 0);
    chk("rd_rs", int'(tr[0][12:9]), 3);
    chk("rd_rsp_edge", rsp_k, 9);
    chk("rd_rsp_we", (rsp_k >= 0) ? int'(tr[rsp_k][24]) : -1, 0);
    chk("rd_rdata", (rsp_k >= 0) ? int'(tr[rsp_k][23:16]) : -1, 8'hC3);

    // Two back-to-back writes with req_valid held
    @(posedge clk); #2;
    v_valid[0] = 1'b1; v_we[0] = 1'b1; v_rs[0] = 4'd2; v_wd[0] = 8'h55;
    p0 = -1; p1 = -1; csb_lo = 0;
    for (int p = 0; p < 60 && p1 < 0; p++) begin
      @(negedge clk);
      if (p0 >= 0 && ov[0][15]) csb_lo++;
      if (ov[0][26] && v_valid[0]) begin
        if (p0 < 0) begin
          p0 = p;
          @(posedge clk); #2;
          v_wd[0] = 8'h66;
        end else begin
          p1 = p;
        end
      end
    end
    @(posedge clk); #2;
    v_valid[0] = 1'b0;
    chk("b2b_accept_spacing", (p1 < 0) ? -1 : p1 - p0, 13);
    chk("b2b_csb_high_cycles", csb_lo, 4);
    repeat (16) @(negedge clk);
    chk("b2b_second_dout", int'(ov[0][8:1]), 8'h66);
    chk("rdata_held_after_writes", int'(ov[0][23:16]), 8'hC3);

    // Reset in the 3rd strobe cycle of a write
    do_req(0, 1'b1, 4'd4, 8'h9A);
    repeat (5) @(negedge clk);
    chk("rst_pre_wrb", int'(ov[0][13]), 0);
    #1 reset = 1'b1;
    #1;
    chk("rst_wrb", int'(ov[0][13]), 1);
    chk("rst_csb", int'(ov[0][15]), 1);
    chk("rst_dout_en", int'(ov[0][0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rsp_hits = 0; rdy_after = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) rdy_after = int'(ov[0][26]);
      rsp_hits += ov[0][25] ? 1 : 0;
    end
    chk("rst_ready_after", rdy_after, 1);
    chk("rst_no_rsp", rsp_hits, 0);

    // All timing parameters at 1: two reads with req_valid held
    rd_val[1] = 8'hA5;
    @(posedge clk); #2;
    v_valid[1] = 1'b1; v_we[1] = 1'b0; v_rs[1] = 4'd5; v_wd[1] = 8'h00;
    p0 = -1; p1 = -1; rsp_p = -1; rsp_d = 8'h00;
    for (int p = 0; p < 40 && p1 < 0; p++) begin
      @(negedge clk);
      if (ov[1][25] && rsp_p < 0) begin
        rsp_p = p;
        rsp_d = ov[1][23:16];
      end
      if (ov[1][26] && v_valid[1]) begin
        if (p0 < 0) p0 = p;
        else        p1 = p;
      end
    end
    @(posedge clk); #2;
    v_valid[1] = 1'b0;
    chk("p1_rsp_edges", (rsp_p < 0) ? -1 : rsp_p - p0 - 1, 3);
    chk("p1_next_accept", (p1 < 0) ? -1 : p1 - p0, 4);
    chk("p1_rdata", int'(rsp_d), 8'hA5);
    repeat (8) @(negedge clk);

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
